// File: rtl/saber_pkg.sv
// Shared defaults and FSM encoding for the Saber decapsulation verify/CMOV sequencer.
package saber_pkg;

  localparam int DEF_AW         = 9;
  localparam int DEF_DW         = 64;
  localparam int DEF_CMOV_WORDS = 4;
  localparam int LEN_W          = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMP,
    ST_DRAIN,
    ST_RK,
    ST_RZ,
    ST_WR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/verify_acc.sv
// OR-of-XOR difference accumulator: captures word A, folds A ^ rdata in on the following cycle.
module verify_acc #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cap,
  input  logic [DW-1:0] rdata,
  output logic          match
);

  logic [DW-1:0] a_word;
  logic [DW-1:0] acc;
  logic          pend;

  // The B word arrives one cycle after A is captured, so the fold is deferred via pend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_word <= '0;
      acc    <= '0;
      pend   <= 1'b0;
    end else if (clr) begin
      a_word <= '0;
      acc    <= '0;
      pend   <= 1'b0;
    end else begin
      pend <= cap;
      if (cap) a_word <= rdata;
      if (pend) acc <= acc | (a_word ^ rdata);
    end
  end

  assign match = (acc == '0);

endmodule

// File: rtl/verify_cmov_ctrl.sv
// Constant-time ciphertext compare followed by a masked K/Z move into the session-key slot.
module verify_cmov_ctrl
  import saber_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int CMOV_WORDS = DEF_CMOV_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cmp_len,
  input  logic [AW-1:0]    base_a,
  input  logic [AW-1:0]    base_b,
  input  logic [AW-1:0]    base_k,
  input  logic [AW-1:0]    base_z,
  input  logic [AW-1:0]    base_dst,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             verify_true
);

  localparam int WCW = $clog2(CMOV_WORDS + 1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, pair_cnt;
  logic             phase;
  logic [WCW-1:0]   word_cnt;
  logic [AW-1:0]    a_q, b_q, k_q, z_q, d_q;
  logic [DW-1:0]    k_word, mask;
  logic [AW-1:0]    pair_off, word_off;
  logic             acc_clr, acc_cap, match, last_pair, last_word;

  assign pair_off  = AW'(pair_cnt);
  assign word_off  = AW'(word_cnt);
  assign last_pair = phase && (pair_cnt == len_q - LEN_W'(1));
  assign last_word = (word_cnt == WCW'(CMOV_WORDS - 1));
  assign mask      = {DW{match}};

  verify_acc #(.DW(DW)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .cap   (acc_cap),
    .rdata (mem_rdata),
    .match (match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      pair_cnt    <= '0;
      phase       <= 1'b0;
      word_cnt    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      z_q         <= '0;
      d_q         <= '0;
      k_word      <= '0;
      verify_true <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          len_q       <= cmp_len;
          a_q         <= base_a;
          b_q         <= base_b;
          k_q         <= base_k;
          z_q         <= base_z;
          d_q         <= base_dst;
          pair_cnt    <= '0;
          phase       <= 1'b0;
          word_cnt    <= '0;
          verify_true <= 1'b0;
        end
        ST_CMP: begin
          phase <= ~phase;
          if (phase) pair_cnt <= pair_cnt + LEN_W'(1);
        end
        ST_RZ: k_word <= mem_rdata;
        ST_WR: begin
          word_cnt <= word_cnt + WCW'(1);
          // Published as DONE is entered so the flag is already valid alongside done.
          if (last_word) verify_true <= match;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    acc_clr   = 1'b0;
    acc_cap   = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        acc_clr   = 1'b1;
        state_nxt = (cmp_len == '0) ? ST_DRAIN : ST_CMP;
      end
      ST_CMP: begin
        mem_addr = phase ? (b_q + pair_off) : (a_q + pair_off);
        acc_cap  = phase;
        if (last_pair) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_RK;
      ST_RK: begin
        mem_addr  = k_q + word_off;
        state_nxt = ST_RZ;
      end
      ST_RZ: begin
        mem_addr  = z_q + word_off;
        state_nxt = ST_WR;
      end
      ST_WR: begin
        // Z arrives on mem_rdata here; both sources are always read and blended by mask.
        mem_addr  = d_q + word_off;
        mem_we    = 1'b1;
        mem_wdata = (k_word & mask) | (mem_rdata & ~mask);
        state_nxt = last_word ? ST_DONE : ST_RK;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_verify_cmov_ctrl.sv
// Bench for verify_cmov_ctrl: directed table plus randomized runs against a behavioural model.
module tb_verify_cmov_ctrl;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [9:0]    cmp_len = '0;
  logic [AW-1:0] base_a = '0, base_b = '0, base_k = '0, base_z = '0, base_dst = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, done, verify_true;

  verify_cmov_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cmp_len(cmp_len),
    .base_a(base_a), .base_b(base_b), .base_k(base_k), .base_z(base_z), .base_dst(base_dst),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .verify_true(verify_true)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:511];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_wdata = '0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_wdata;
  end

  int trace_q[$];
  int exp_q[$];
  int done_cnt = 0;
  int wd_viol = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) trace_q.push_back(int'(mem_addr));
      if (done) done_cnt++;
      if (!mem_we && mem_wdata != '0) wd_viol++;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a; bd_wdata = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_op(input int n, input logic [AW-1:0] ba, bb, bk, bz, bd,
                        input int restart, output int cyc, output bit got);
    trace_q.delete(); done_cnt = 0; wd_viol = 0;
    cmp_len = 10'(n); base_a = ba; base_b = bb; base_k = bk; base_z = bz; base_dst = bd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; got = 1'b0;
    while (!got && cyc < 400) begin
      if (done) got = 1'b1;
      else begin
        start = (cyc == restart);
        if (start) begin
          cmp_len = 10'd7; base_a = 9'd0; base_dst = 9'd0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input int n, input logic [AW-1:0] ba, bb, bk, bz, bd,
                       input int flip, input int fbit, input int restart,
                       input logic [63:0] kbase, input logic [63:0] zbase,
                       input int exp_vt_in, input int exp_cyc_in);
    logic [63:0] av[$];
    logic [63:0] bv[$];
    logic [63:0] w;
    logic [63:0] kw[W];
    logic [63:0] zw[W];
    int cyc, evt, ecyc, bad;
    bit got;
    for (int i = 0; i < n; i++) begin
      w = {$urandom(), $urandom()};
      av.push_back(w);
      if (i == flip) w[fbit] = ~w[fbit];
      bv.push_back(w);
      poke(AW'(ba + 9'(i)), av[i]);
      poke(AW'(bb + 9'(i)), w);
    end
    for (int j = 0; j < W; j++) begin
      kw[j] = kbase + 64'(j);
      zw[j] = zbase + 64'(j);
      poke(AW'(bk + 9'(j)), kw[j]);
      poke(AW'(bz + 9'(j)), zw[j]);
      poke(AW'(bd + 9'(j)), 64'hDEAD_BEEF_0000_0000 | 64'(j));
    end
    // Reference: equal iff every pair matches; addresses follow the phase schedule.
    evt = 1;
    for (int i = 0; i < n; i++) if (av[i] != bv[i]) evt = 0;
    if (exp_vt_in >= 0) evt = exp_vt_in;
    ecyc = (exp_cyc_in >= 0) ? exp_cyc_in : 2 * n + 3 * W + 2;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back((int'(ba) + i) % 512);
      exp_q.push_back((int'(bb) + i) % 512);
    end
    exp_q.push_back(0);
    for (int j = 0; j < W; j++) begin
      exp_q.push_back((int'(bk) + j) % 512);
      exp_q.push_back((int'(bz) + j) % 512);
      exp_q.push_back((int'(bd) + j) % 512);
    end
    exp_q.push_back(0);

    run_op(n, ba, bb, bk, bz, bd, restart, cyc, got);
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(ecyc));
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check({tag, "_verify_true"}, 64'(verify_true), 64'(evt));
    for (int j = 0; j < W; j++)
      check({tag, "_dst", $sformatf("%0d", j)}, mem[AW'(bd + 9'(j))], (evt != 0) ? kw[j] : zw[j]);
    bad = 0;
    if (trace_q.size() != exp_q.size()) bad = 1000 + trace_q.size();
    else for (int i = 0; i < exp_q.size(); i++) if (trace_q[i] != exp_q[i]) bad++;
    check({tag, "_addr_seq"}, 64'(bad), 64'd0);
    check({tag, "_wdata_idle"}, 64'(wd_viol), 64'd0);
  endtask

  typedef struct {
    string         name;
    int            n;
    logic [AW-1:0] ba, bb, bk, bz, bd;
    int            flip;
    int            restart;
    int            exp_vt;
    int            exp_cyc;
  } vec_t;

  function automatic vec_t mk(string name, int n, logic [AW-1:0] ba, bb, bk, bz, bd,
                              int flip, int restart, int exp_vt, int exp_cyc);
    vec_t v;
    v.name = name; v.n = n; v.ba = ba; v.bb = bb; v.bk = bk; v.bz = bz; v.bd = bd;
    v.flip = flip; v.restart = restart; v.exp_vt = exp_vt; v.exp_cyc = exp_cyc;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int cyc, wr_seen, n, flip;
    logic [AW-1:0] ba, bb, bk, bz, bd;

    vecs.push_back(mk("match_n3",     3, 9'd16,  9'd64,  9'd256, 9'd300, 9'd400, -1, -1, 1, 20));
    vecs.push_back(mk("miss_bit63",   3, 9'd16,  9'd64,  9'd256, 9'd300, 9'd400,  2, -1, 0, 20));
    vecs.push_back(mk("len_zero",     0, 9'd16,  9'd64,  9'd256, 9'd300, 9'd400, -1, -1, 1, 14));
    vecs.push_back(mk("restart_busy", 3, 9'd16,  9'd64,  9'd256, 9'd300, 9'd400, -1,  2, 1, 20));
    vecs.push_back(mk("wrap_match",   2, 9'd511, 9'd200, 9'd300, 9'd340, 9'd400, -1, -1, 1, 18));
    vecs.push_back(mk("wrap_miss",    2, 9'd511, 9'd200, 9'd300, 9'd340, 9'd400,  1, -1, 0, 18));

    repeat (3) @(negedge clk);
    check("rst_ctrl", {59'd0, busy, done, mem_we, verify_true, 1'b0}, 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].n, vecs[i].ba, vecs[i].bb, vecs[i].bk, vecs[i].bz, vecs[i].bd,
            vecs[i].flip, 63, vecs[i].restart, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            vecs[i].exp_vt, vecs[i].exp_cyc);

    // Reset landing in the second write cycle, then a fresh mismatching run.
    for (int i = 0; i < 3; i++) begin
      poke(AW'(9'd16 + 9'(i)), 64'(i) * 64'h0101);
      poke(AW'(9'd64 + 9'(i)), 64'(i) * 64'h0101);
    end
    trace_q.delete(); done_cnt = 0;
    cmp_len = 10'd3; base_a = 9'd16; base_b = 9'd64; base_k = 9'd256; base_z = 9'd300; base_dst = 9'd400;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_seen = 0; cyc = 0;
    while (wr_seen < 2 && cyc < 100) begin
      if (mem_we) wr_seen++;
      if (wr_seen < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("rst_mid_wr_reached", 64'(wr_seen), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ctrl", {59'd0, busy, done, mem_we, verify_true, 1'b0}, 64'd0);
    check("rst_mid_addr", 64'(mem_addr), 64'd0);
    check("rst_mid_wdata", mem_wdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op("after_rst", 2, 9'd20, 9'd70, 9'd260, 9'd310, 9'd410, 0, 5, -1,
          64'hAAAA_0000_0000_0000, 64'h5555_0000_0000_0000, 0, 18);

    for (int r = 0; r < 25; r++) begin
      n  = $urandom_range(0, 20);
      ba = 9'($urandom_range(0, 100));
      bb = 9'($urandom_range(128, 200));
      bk = 9'($urandom_range(256, 290));
      bz = 9'($urandom_range(320, 350));
      bd = 9'($urandom_range(400, 450));
      flip = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
      do_op($sformatf("rand%0d", r), n, ba, bb, bk, bz, bd, flip, int'($urandom_range(0, 63)),
            -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
